leading_one_scan: RTL and testbench

Parametrised, multi-cycle leading/trailing-one detector for the bit-manipulation datapath. It accepts a WIDTH-bit word over a valid/ready handshake and scans it CHUNK bits per clock, starting from the MSB (leading-one mode) or the LSB (trailing-one mode). It returns the bit position of the first set bit found, plus a zero flag, over a valid/ready output handshake. It extends the 8-bit combinational leading-one detector with configurable width and throughput/area trade-off, a trailing-one mode, and flow control for normaliser and priority-encoder users.

---
 rtl/leading_one_scan.sv | 104 ++++++++++
 tb/tb_leading_one_scan.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/leading_one_scan.sv
// rtl/leading_one_scan.sv - multi-cycle leading/trailing-one detector with valid/ready handshakes
// Scans CHUNK bits per clock from the MSB (mode 0) or LSB (mode 1) and reports the first set bit.
module leading_one_scan #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         in_data,
   input  logic                     in_mode,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [$clog2(WIDTH)-1:0] out_pos,
   output logic                     out_zero
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int POS_W  = $clog2(WIDTH);
   localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t             state;
   logic [WIDTH-1:0]   data_q;
   logic               mode_q;
   logic [IDX_W-1:0]   idx_q;

   logic [CHUNK-1:0]   chunk;
   logic               chunk_nz;
   logic               last_chunk;
   logic [POS_W-1:0]   hit_pos;
   logic [IDX_W-1:0]   first_idx;
   int                 offset;

   always_comb begin
      chunk  = CHUNK'(data_q >> (idx_q * CHUNK));
      offset = 0;
      // Later hits overwrite earlier ones, so the loop direction picks highest or lowest bit.
      if (mode_q) begin
         for (int i = CHUNK - 1; i >= 0; i--) begin
            if (chunk[i]) offset = i;
         end
      end else begin
         for (int i = 0; i < CHUNK; i++) begin
            if (chunk[i]) offset = i;
         end
      end
      hit_pos    = POS_W'(int'(idx_q) * CHUNK + offset);
      chunk_nz   = |chunk;
      last_chunk = mode_q ? (idx_q == IDX_W'(NCHUNK - 1)) : (idx_q == '0);
      first_idx  = in_mode ? '0 : IDX_W'(NCHUNK - 1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         data_q    <= '0;
         mode_q    <= 1'b0;
         idx_q     <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_pos   <= '0;
         out_zero  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  data_q   <= in_data;
                  mode_q   <= in_mode;
                  idx_q    <= first_idx;
                  in_ready <= 1'b0;
                  state    <= SCAN;
               end
            end
            SCAN: begin
               if (chunk_nz) begin
                  out_pos   <= hit_pos;
                  out_zero  <= 1'b0;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else if (last_chunk) begin
                  out_pos   <= '0;
                  out_zero  <= 1'b1;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  idx_q <= mode_q ? idx_q + IDX_W'(1) : idx_q - IDX_W'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_leading_one_scan.sv
// tb/tb_leading_one_scan.sv - randomized bench for leading_one_scan at CHUNK = 4, 1 and 16
// All three instances see the same words; results and latencies come from an arithmetic model.
module tb_leading_one_scan;

   localparam int WIDTH = 16;
   localparam int NINST = 3;

   logic                        clk = 1'b0;
   logic                        rst_n;
   logic                        in_valid;
   logic                        in_mode;
   logic                        out_ready;
   logic [WIDTH-1:0]            in_data;
   logic [NINST-1:0]            in_ready_v;
   logic [NINST-1:0]            out_valid_v;
   logic [NINST-1:0]            out_zero_v;
   logic [NINST-1:0][3:0]       out_pos_v;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   leading_one_scan #(.WIDTH(WIDTH), .CHUNK(4)) u_c4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_v[0]),
      .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid_v[0]),
      .out_ready(out_ready), .out_pos(out_pos_v[0]), .out_zero(out_zero_v[0]));

   leading_one_scan #(.WIDTH(WIDTH), .CHUNK(1)) u_c1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_v[1]),
      .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid_v[1]),
      .out_ready(out_ready), .out_pos(out_pos_v[1]), .out_zero(out_zero_v[1]));

   leading_one_scan #(.WIDTH(WIDTH), .CHUNK(16)) u_c16 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_v[2]),
      .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid_v[2]),
      .out_ready(out_ready), .out_pos(out_pos_v[2]), .out_zero(out_zero_v[2]));

   function automatic int chunk_of(input int i);
      case (i)
         0:       return 4;
         1:       return 1;
         default: return 16;
      endcase
   endfunction

   // Leading one = floor(log2(v)); trailing one = log2 of the isolated lowest set bit.
   function automatic int ref_pos(input logic [WIDTH-1:0] d, input logic m);
      int v;
      v = int'(d);
      if (v == 0) return 0;
      if (m == 1'b0) return $clog2(v + 1) - 1;
      return $clog2(v & -v);
   endfunction

   function automatic int ref_lat(input logic [WIDTH-1:0] d, input logic m, input int c);
      int n;
      int q;
      n = WIDTH / c;
      q = ref_pos(d, m) / c;
      if (d == '0) return n;
      return m ? q + 1 : n - q;
   endfunction

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (in_ready_v != '1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("wait_idle", int'(in_ready_v), (1 << NINST) - 1);
   endtask

   task automatic run_word(input logic [WIDTH-1:0] d, input logic m);
      logic [NINST-1:0] done;
      done = '0;
      wait_idle();
      in_data  = d;
      in_mode  = m;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = 16'($urandom);
      in_mode  = 1'($urandom);
      for (int cyc = 1; cyc <= 40 && done != '1; cyc++) begin
         @(posedge clk);
         @(negedge clk);
         for (int i = 0; i < NINST; i++) begin
            if (!done[i]) begin
               if (out_valid_v[i]) begin
                  done[i] = 1'b1;
                  check($sformatf("lat c%0d d=%h m=%0d", chunk_of(i), d, m), cyc,
                        ref_lat(d, m, chunk_of(i)));
                  check($sformatf("pos c%0d d=%h m=%0d", chunk_of(i), d, m),
                        int'(out_pos_v[i]), ref_pos(d, m));
                  check($sformatf("zero c%0d d=%h m=%0d", chunk_of(i), d, m),
                        int'(out_zero_v[i]), int'(d == '0));
               end else begin
                  check($sformatf("busy_in_ready c%0d", chunk_of(i)), int'(in_ready_v[i]), 0);
               end
            end
         end
      end
      check($sformatf("result_seen d=%h", d), int'(done), (1 << NINST) - 1);
   endtask

   task automatic backpressure_test();
      int n;
      wait_idle();
      out_ready = 1'b0;
      in_data   = 16'h002D;
      in_mode   = 1'b0;
      in_valid  = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      n = 0;
      while (out_valid_v != '1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("bp_all_valid", int'(out_valid_v), (1 << NINST) - 1);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         for (int i = 0; i < NINST; i++) begin
            check($sformatf("bp_valid c%0d k%0d", chunk_of(i), k), int'(out_valid_v[i]), 1);
            check($sformatf("bp_pos c%0d k%0d", chunk_of(i), k), int'(out_pos_v[i]), 5);
            check($sformatf("bp_zero c%0d k%0d", chunk_of(i), k), int'(out_zero_v[i]), 0);
            check($sformatf("bp_in_ready c%0d k%0d", chunk_of(i), k), int'(in_ready_v[i]), 0);
         end
         in_valid = 1'b1;
         in_data  = 16'($urandom);
         in_mode  = 1'($urandom);
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_release_valid", int'(out_valid_v), 0);
      check("bp_release_in_ready", int'(in_ready_v), (1 << NINST) - 1);
      run_word(16'h4000, 1'b0);
   endtask

   task automatic reset_mid_scan_test();
      wait_idle();
      in_data  = 16'h0001;
      in_mode  = 1'b0;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_async_in_ready", int'(in_ready_v), (1 << NINST) - 1);
      check("rst_async_out_valid", int'(out_valid_v), 0);
      check("rst_async_out_pos", int'(out_pos_v), 0);
      check("rst_async_out_zero", int'(out_zero_v), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("rst_no_stale_valid", int'(out_valid_v), 0);
      end
      run_word(16'h0100, 1'b0);
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_mode   = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      for (int i = 0; i < NINST; i++) begin
         check($sformatf("reset_in_ready c%0d", chunk_of(i)), int'(in_ready_v[i]), 1);
         check($sformatf("reset_out_valid c%0d", chunk_of(i)), int'(out_valid_v[i]), 0);
         check($sformatf("reset_out_pos c%0d", chunk_of(i)), int'(out_pos_v[i]), 0);
         check($sformatf("reset_out_zero c%0d", chunk_of(i)), int'(out_zero_v[i]), 0);
      end
      rst_n = 1'b1;

      run_word(16'h000E, 1'b0);
      run_word(16'h002D, 1'b0);
      run_word(16'h8000, 1'b0);
      run_word(16'h0000, 1'b0);
      run_word(16'h0000, 1'b1);
      run_word(16'h002D, 1'b1);
      run_word(16'h8000, 1'b1);
      run_word(16'h0100, 1'b0);
      run_word(16'hFFFF, 1'b0);
      run_word(16'hFFFF, 1'b1);

      backpressure_test();
      reset_mid_scan_test();

      repeat (60) begin
         logic [WIDTH-1:0] d;
         case ($urandom_range(0, 3))
            0:       d = 16'($urandom);
            1:       d = 16'(1) << $urandom_range(0, WIDTH - 1);
            2:       d = (16'(1) << $urandom_range(0, WIDTH - 1)) | (16'(1) << $urandom_range(0, WIDTH - 1));
            default: d = 16'($urandom) & 16'($urandom) & 16'($urandom);
         endcase
         run_word(d, 1'($urandom));
      end

      wait_idle();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, got %0d passed of %0d", n_pass, n_checks);
      $fatal(1);
   end

endmodule
